// File: rtl/fc.sv
// Shared Fibre Channel port-state package.
// Holds the Table 22 port-state type, the recognised-primitive type, the
// ordered-set word values (K28.5 in byte 3), the word-to-primitive mapping
// and the next-state function.
// The next-state function lives here so the transmit side can reuse the same
// transition table.
package fc;

  typedef enum logic [3:0] {
    ST_AC  = 4'd0,
    ST_LR1 = 4'd1,
    ST_LR2 = 4'd2,
    ST_LR3 = 4'd3,
    ST_LF1 = 4'd4,
    ST_LF2 = 4'd5,
    ST_OL1 = 4'd6,
    ST_OL2 = 4'd7,
    ST_OL3 = 4'd8
  } state_t;

  typedef enum logic [3:0] {
    PRIM_NONE  = 4'd0,
    PRIM_IDLE  = 4'd1,
    PRIM_ARBFF = 4'd2,
    PRIM_RRDY  = 4'd3,
    PRIM_NOS   = 4'd4,
    PRIM_OLS   = 4'd5,
    PRIM_LR    = 4'd6,
    PRIM_LRR   = 4'd7,
    PRIM_OTHER = 4'd8
  } prim_t;

  // datak pattern that marks an ordered set: only the K28.5 byte is a K-char.
  localparam logic [3:0] OS_K_FLAGS = 4'b1000;

  localparam logic [31:0] OS_IDLE  = 32'hBC95_B5B5;
  localparam logic [31:0] OS_RRDY  = 32'hBC95_4A4A;
  localparam logic [31:0] OS_ARBFF = 32'hBC94_FFFF;
  localparam logic [31:0] OS_NOS   = 32'hBC55_BF45;
  localparam logic [31:0] OS_OLS   = 32'hBC35_8A55;
  localparam logic [31:0] OS_LR    = 32'hBC49_BF49;
  localparam logic [31:0] OS_LRR   = 32'hBC35_BF49;

  // Any ordered set that is not one of the known words is PRIM_OTHER.
  function automatic prim_t map_primitive(input logic [31:0] word);
    prim_t p;
    case (word)
      OS_IDLE:  p = PRIM_IDLE;
      OS_RRDY:  p = PRIM_RRDY;
      OS_ARBFF: p = PRIM_ARBFF;
      OS_NOS:   p = PRIM_NOS;
      OS_OLS:   p = PRIM_OLS;
      OS_LR:    p = PRIM_LR;
      OS_LRR:   p = PRIM_LRR;
      default:  p = PRIM_OTHER;
    endcase
    return p;
  endfunction

  // Primitive sequences: act only after a run of identical ordered sets.
  function automatic logic is_seq_prim(input prim_t p);
    return (p == PRIM_OLS) || (p == PRIM_NOS) || (p == PRIM_LR) || (p == PRIM_LRR);
  endfunction

  // Primitive signals: act on every occurrence.
  function automatic logic is_signal_prim(input prim_t p);
    return (p == PRIM_IDLE) || (p == PRIM_ARBFF);
  endfunction

  function automatic state_t next_state(input state_t cur, input prim_t p);
    state_t n;
    n = cur;
    case (p)
      PRIM_OLS: n = ST_OL2;
      PRIM_NOS: n = ST_LF1;
      PRIM_LR:  n = (cur == ST_OL3 || cur == ST_LF2) ? ST_LF2 : ST_LR2;
      PRIM_LRR: begin
        case (cur)
          ST_LF1, ST_LF2, ST_OL1: n = cur;
          ST_OL3:                 n = ST_LF2;
          default:                n = ST_LR3;
        endcase
      end
      PRIM_IDLE, PRIM_ARBFF: begin
        case (cur)
          ST_AC, ST_LR2, ST_LR3: n = ST_AC;
          ST_OL2, ST_OL3:        n = ST_OL2;
          default:               n = cur;
        endcase
      end
      default: n = cur;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/fc_prim_seq_detect.sv
// Primitive run detector.
// It classifies each qualified receive word and counts runs of identical
// ordered sets.
// recognised is a combinational strobe for the current word:
//   - primitive sequences (OLS/NOS/LR/LRR) strobe once the run, including this
//     word, reaches SEQ_MATCH, and keep strobing on each further matching word;
//   - primitive signals (IDLE/ARBFF) strobe on every occurrence.
// Ports:
//   clk, reset_n    word clock, async active-low reset
//   data, datak     received word and K-flags
//   sync_ok         word stream is valid only while high
//   prim            primitive carried by the current word (PRIM_NONE if not an ordered set)
//   recognised      current word should be acted on
module fc_prim_seq_detect
  import fc::*;
#(
  parameter int SEQ_MATCH = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] data,
  input  logic [3:0]  datak,
  input  logic        sync_ok,
  output prim_t       prim,
  output logic        recognised
);

  localparam logic [3:0] MATCH = 4'(SEQ_MATCH);

  logic [3:0] seq_cnt;
  logic [3:0] seq_cnt_next;
  prim_t      last_prim;
  prim_t      last_prim_next;
  logic       is_os;

  assign is_os = sync_ok && (datak == OS_K_FLAGS);
  assign prim  = is_os ? map_primitive(data) : PRIM_NONE;

  // A run is broken by any non-ordered-set word or by loss of sync.
  always_comb begin
    seq_cnt_next   = 4'd0;
    last_prim_next = PRIM_NONE;
    recognised     = 1'b0;
    if (is_os) begin
      if (prim == last_prim) begin
        last_prim_next = last_prim;
        seq_cnt_next   = (seq_cnt >= MATCH) ? MATCH : seq_cnt + 4'd1;
      end else begin
        last_prim_next = prim;
        seq_cnt_next   = 4'd1;
      end
      recognised = is_signal_prim(prim) || (is_seq_prim(prim) && (seq_cnt_next >= MATCH));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seq_cnt   <= 4'd0;
      last_prim <= PRIM_NONE;
    end else begin
      seq_cnt   <= seq_cnt_next;
      last_prim <= last_prim_next;
    end
  end

endmodule

// File: rtl/fc_state_rx_seq.sv
// Receive-side FC port state tracker.
// It follows the decoded 32-bit receive word stream and maintains the port
// state (AC, LR1-3, LF1-2, OL1-3). It also provides:
//   - a loss-of-sync timeout that forces LF1;
//   - an active-entry hold-off before is_active;
//   - a saturating link-failure counter.
// The word stream carries no handshake; a word is consumed on every clock
// where sync_ok is high, and ignored otherwise.
// Ports:
//   clk, reset_n   word clock, async active-low reset
//   data, datak    received word (K28.5 in byte 3 for ordered sets) and K-flags
//   sync_ok        word sync valid from the aligner
//   cnt_clear      synchronous clear of link_fail_cnt
//   state          registered port state
//   is_active      state is AC and the hold-off has expired
//   state_change   one-clock pulse in the first cycle state shows a new value
//   los_timeout    one-clock pulse when loss of sync forces LF1
//   link_fail_cnt  saturating count of entries into LF1/LF2
module fc_state_rx_seq
  import fc::*;
#(
  parameter int SEQ_MATCH    = 3,
  parameter int IDLE_HOLDOFF = 6,
  parameter int LOS_TIMEOUT  = 65536,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [31:0]      data,
  input  logic [3:0]       datak,
  input  logic             sync_ok,
  input  logic             cnt_clear,
  output state_t           state,
  output logic             is_active,
  output logic             state_change,
  output logic             los_timeout,
  output logic [CNT_W-1:0] link_fail_cnt
);

  localparam int               LOS_W     = 25;
  localparam logic [LOS_W-1:0] LOS_LIMIT = LOS_W'(LOS_TIMEOUT);
  localparam logic [7:0]       HOLD_INIT = 8'(IDLE_HOLDOFF);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  prim_t            prim;
  logic             recognised;
  state_t           state_next;
  logic [LOS_W-1:0] los_cnt;
  logic             los_fire;
  logic [7:0]       hold;
  logic             fail_entry;

  fc_prim_seq_detect #(
    .SEQ_MATCH (SEQ_MATCH)
  ) u_seq (
    .clk        (clk),
    .reset_n    (reset_n),
    .data       (data),
    .datak      (datak),
    .sync_ok    (sync_ok),
    .prim       (prim),
    .recognised (recognised)
  );

  // Fires on the clock the LOS counter reaches its limit; the counter then
  // parks at the limit, so there is one pulse per loss-of-sync episode.
  assign los_fire = (LOS_TIMEOUT != 0) && !sync_ok && (los_cnt == LOS_LIMIT - LOS_W'(1));

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_LF2;
      state_change <= 1'b0;
      los_timeout  <= 1'b0;
    end else begin
      state        <= state_next;
      state_change <= (state_next != state);
      los_timeout  <= los_fire;
    end
  end

  // Next-state logic. recognised is already qualified by sync_ok, so it never
  // competes with los_fire.
  always_comb begin
    state_next = state;
    if (los_fire) begin
      state_next = ST_LF1;
    end else if (recognised) begin
      state_next = next_state(state, prim);
    end
  end

  // Output logic.
  always_comb begin
    is_active = (state == ST_AC) && (hold == 8'd0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      los_cnt <= '0;
    end else if (LOS_TIMEOUT == 0 || sync_ok) begin
      los_cnt <= '0;
    end else if (los_cnt != LOS_LIMIT) begin
      los_cnt <= los_cnt + LOS_W'(1);
    end
  end

  // Hold-off counts clocks spent in AC.
  // It is reloaded by any cycle outside AC.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold <= HOLD_INIT;
    end else if (state != ST_AC) begin
      hold <= HOLD_INIT;
    end else if (hold != 8'd0) begin
      hold <= hold - 8'd1;
    end
  end

  assign fail_entry = (state_next == ST_LF1 || state_next == ST_LF2) &&
                      !(state == ST_LF1 || state == ST_LF2);

  // A clear in the same clock as a new failure keeps that failure.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      link_fail_cnt <= '0;
    end else if (cnt_clear) begin
      link_fail_cnt <= fail_entry ? CNT_W'(1) : '0;
    end else if (fail_entry && link_fail_cnt != CNT_MAX) begin
      link_fail_cnt <= link_fail_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fc_state_rx_seq.sv
// Self-checking bench for fc_state_rx_seq.
// The reference model tracks the port as plain quantities:
//   - run length of identical ordered sets;
//   - consecutive clocks without sync;
//   - consecutive clocks spent in AC;
//   - the failure count.
// Expected outputs are derived from these every cycle.
// Directed scenarios pin both the DUT and the model to hand-computed values;
// a randomized phase follows.
module tb_fc_state_rx_seq;
  import fc::*;

  localparam int SEQ_MATCH    = 3;
  localparam int IDLE_HOLDOFF = 6;
  localparam int LOS_TIMEOUT  = 16;
  localparam int CNT_W        = 2;
  localparam int CNT_SAT      = (1 << CNT_W) - 1;

  // Primitive identifiers used by the driver and the model.
  localparam int P_NONE  = 0;
  localparam int P_IDLE  = 1;
  localparam int P_ARBFF = 2;
  localparam int P_RRDY  = 3;
  localparam int P_NOS   = 4;
  localparam int P_OLS   = 5;
  localparam int P_LR    = 6;
  localparam int P_LRR   = 7;
  localparam int P_OTHER = 8;

  // ---------------- clock / reset ----------------
  logic             clk;
  logic             reset_n;
  logic [31:0]      data;
  logic [3:0]       datak;
  logic             sync_ok;
  logic             cnt_clear;
  state_t           state;
  logic             is_active;
  logic             state_change;
  logic             los_timeout;
  logic [CNT_W-1:0] link_fail_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fc_state_rx_seq #(
    .SEQ_MATCH    (SEQ_MATCH),
    .IDLE_HOLDOFF (IDLE_HOLDOFF),
    .LOS_TIMEOUT  (LOS_TIMEOUT),
    .CNT_W        (CNT_W)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .data          (data),
    .datak         (datak),
    .sync_ok       (sync_ok),
    .cnt_clear     (cnt_clear),
    .state         (state),
    .is_active     (is_active),
    .state_change  (state_change),
    .los_timeout   (los_timeout),
    .link_fail_cnt (link_fail_cnt)
  );

  // ---------------- counters ----------------
  int n_checks;
  int n_fail;

  // ---------------- reference model ----------------
  int     drv_prim;
  state_t m_state;
  int     m_run;
  int     m_last;
  int     m_los_run;
  int     m_ac_cycles;
  int     m_cnt;
  logic   m_change;
  logic   m_los_pulse;
  state_t m_nxt;
  logic   m_entry;

  function automatic logic [31:0] word_of(input int p);
    case (p)
      P_IDLE:  return 32'hBC95_B5B5;
      P_ARBFF: return 32'hBC94_FFFF;
      P_RRDY:  return 32'hBC95_4A4A;
      P_NOS:   return 32'hBC55_BF45;
      P_OLS:   return 32'hBC35_8A55;
      P_LR:    return 32'hBC49_BF49;
      P_LRR:   return 32'hBC35_BF49;
      default: return 32'hBCB5_5656;
    endcase
  endfunction

  function automatic state_t model_next(input state_t x, input int p);
    if (p == P_OLS) return ST_OL2;
    if (p == P_NOS) return ST_LF1;
    if (p == P_LR) return (x inside {ST_OL3, ST_LF2}) ? ST_LF2 : ST_LR2;
    if (p == P_LRR) begin
      if (x inside {ST_LF1, ST_LF2, ST_OL1}) return x;
      if (x == ST_OL3) return ST_LF2;
      return ST_LR3;
    end
    if (x inside {ST_AC, ST_LR2, ST_LR3}) return ST_AC;
    if (x inside {ST_OL2, ST_OL3}) return ST_OL2;
    return x;
  endfunction

  function automatic logic in_fail(input state_t x);
    return (x == ST_LF1) || (x == ST_LF2);
  endfunction

  function automatic logic exp_active();
    return (m_state == ST_AC) && (m_ac_cycles >= IDLE_HOLDOFF);
  endfunction

  task automatic model_reset();
    m_state     = ST_LF2;
    m_run       = 0;
    m_last      = P_NONE;
    m_los_run   = 0;
    m_ac_cycles = 0;
    m_cnt       = 0;
    m_change    = 1'b0;
    m_los_pulse = 1'b0;
  endtask

  // Called once per clock edge with the inputs that edge sampled.
  task automatic model_update();
    m_nxt       = m_state;
    m_los_pulse = 1'b0;
    if (m_state == ST_AC) m_ac_cycles++;
    else m_ac_cycles = 0;
    if (!sync_ok) begin
      m_run  = 0;
      m_last = P_NONE;
      m_los_run++;
      if (LOS_TIMEOUT != 0 && m_los_run == LOS_TIMEOUT) begin
        m_nxt       = ST_LF1;
        m_los_pulse = 1'b1;
      end
    end else begin
      m_los_run = 0;
      if (drv_prim == P_NONE) begin
        m_run  = 0;
        m_last = P_NONE;
      end else begin
        if (drv_prim == m_last) m_run++;
        else begin
          m_run  = 1;
          m_last = drv_prim;
        end
        if ((drv_prim inside {P_OLS, P_NOS, P_LR, P_LRR} && m_run >= SEQ_MATCH) ||
            (drv_prim inside {P_IDLE, P_ARBFF}))
          m_nxt = model_next(m_state, drv_prim);
      end
    end
    m_entry = in_fail(m_nxt) && !in_fail(m_state);
    if (cnt_clear) m_cnt = m_entry ? 1 : 0;
    else if (m_entry) m_cnt = (m_cnt + 1 > CNT_SAT) ? CNT_SAT : m_cnt + 1;
    m_change = (m_nxt != m_state);
    m_state  = m_nxt;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("state",         32'(state),         32'(m_state));
    check("is_active",     32'(is_active),     32'(exp_active()));
    check("state_change",  32'(state_change),  32'(m_change));
    check("los_timeout",   32'(los_timeout),   32'(m_los_pulse));
    check("link_fail_cnt", 32'(link_fail_cnt), 32'(m_cnt));
  endtask

  // Pins a hand-computed value on both the DUT and the model.
  task automatic pin(input string nm, input logic [31:0] dut_v, input logic [31:0] mdl_v,
                     input logic [31:0] exp);
    check({nm, "_dut"}, dut_v, exp);
    check({nm, "_model"}, mdl_v, exp);
  endtask

  task automatic pin_state(input string nm, input state_t exp);
    pin(nm, 32'(state), 32'(m_state), 32'(exp));
  endtask

  // ---------------- driver ----------------
  task automatic drive(input int p, input logic s, input logic clr);
    int k;
    drv_prim  = p;
    sync_ok   = s;
    cnt_clear = clr;
    if (p == P_NONE) begin
      k = $urandom_range(0, 15);
      if (k == 8) k = 0;
      datak = 4'(k);
      data  = ($urandom_range(0, 1) == 0) ? $urandom : word_of($urandom_range(1, 8));
    end else begin
      datak = 4'b1000;
      data  = word_of(p);
    end
  endtask

  task automatic step(input int p, input logic s, input logic clr);
    drive(p, s, clr);
    @(posedge clk);
    if (reset_n) model_update();
    @(negedge clk);
    compare_all();
  endtask

  task automatic steps(input int p, input int n);
    for (int i = 0; i < n; i++) step(p, 1'b1, 1'b0);
  endtask

  task automatic mid_reset();
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    step(P_NONE, 1'b1, 1'b0);
    step(P_OLS, 1'b1, 1'b0);
    reset_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int prev_p;
    int low_left;
    int p;
    logic s;
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    model_reset();
    drive(P_NONE, 1'b1, 1'b0);
    repeat (3) step(P_NONE, 1'b1, 1'b0);
    pin_state("reset_state", ST_LF2);
    pin("reset_cnt", 32'(link_fail_cnt), 32'(m_cnt), 0);
    reset_n = 1'b1;

    // LR from LF2 stays in LF2.
    steps(P_LR, 3);
    pin_state("lr_in_lf2", ST_LF2);
    pin("lr_in_lf2_chg", 32'(state_change), 32'(m_change), 0);
    pin("lr_in_lf2_cnt", 32'(link_fail_cnt), 32'(m_cnt), 0);

    // LF2 -> OL2 on the third OLS.
    steps(P_OLS, 2);
    pin_state("ols_two", ST_LF2);
    steps(P_OLS, 1);
    pin_state("ols_three", ST_OL2);
    pin("ols_chg", 32'(state_change), 32'(m_change), 1);

    // OL2 -> LR3 -> AC.
    steps(P_LRR, 3);
    pin_state("lrr_three", ST_LR3);
    steps(P_IDLE, 1);
    pin_state("idle_ac", ST_AC);
    pin("idle_ac_act", 32'(is_active), 32'(exp_active()), 0);
    steps(P_IDLE, IDLE_HOLDOFF - 1);
    pin("holdoff_minus1", 32'(is_active), 32'(exp_active()), 0);
    steps(P_IDLE, 1);
    pin("holdoff_done", 32'(is_active), 32'(exp_active()), 1);

    // A data word breaks an LR run.
    steps(P_LR, 2);
    step(P_NONE, 1'b1, 1'b0);
    steps(P_LR, 2);
    pin_state("lr_broken", ST_AC);
    steps(P_LR, 1);
    pin_state("lr_run", ST_LR2);

    // Back to active, then lose sync.
    steps(P_IDLE, 1 + IDLE_HOLDOFF);
    for (int i = 0; i < LOS_TIMEOUT - 1; i++) step(P_IDLE, 1'b0, 1'b0);
    pin_state("los_before", ST_AC);
    pin("los_before_pulse", 32'(los_timeout), 32'(m_los_pulse), 0);
    step(P_IDLE, 1'b0, 1'b0);
    pin_state("los_fire", ST_LF1);
    pin("los_pulse", 32'(los_timeout), 32'(m_los_pulse), 1);
    pin("los_cnt", 32'(link_fail_cnt), 32'(m_cnt), 1);
    pin("los_act", 32'(is_active), 32'(exp_active()), 0);
    step(P_IDLE, 1'b0, 1'b0);
    pin("los_single", 32'(los_timeout), 32'(m_los_pulse), 0);
    for (int i = 0; i < 20; i++) step(P_NONE, 1'b0, 1'b0);

    // Failure count saturation.
    for (int i = 0; i < 4; i++) begin
      steps(P_OLS, 3);
      steps(P_NOS, 3);
    end
    pin("cnt_sat", 32'(link_fail_cnt), 32'(m_cnt), 3);
    steps(P_OLS, 3);
    steps(P_NOS, 2);
    step(P_NOS, 1'b1, 1'b1);
    pin("clr_with_entry", 32'(link_fail_cnt), 32'(m_cnt), 1);
    step(P_NONE, 1'b1, 1'b1);
    pin("clr_alone", 32'(link_fail_cnt), 32'(m_cnt), 0);

    // Reset in the middle of an OLS run.
    steps(P_OLS, 2);
    mid_reset();
    steps(P_OLS, 1);
    pin_state("post_reset", ST_LF2);
    pin("post_reset_chg", 32'(state_change), 32'(m_change), 0);
    pin("post_reset_los", 32'(los_timeout), 32'(m_los_pulse), 0);
    pin("post_reset_act", 32'(is_active), 32'(exp_active()), 0);

    // Randomized phase.
    prev_p   = P_IDLE;
    low_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (prev_p != P_NONE && $urandom_range(0, 99) < 55) p = prev_p;
      else p = $urandom_range(0, 8);
      if (low_left == 0 && $urandom_range(0, 149) == 0) low_left = $urandom_range(1, 30);
      s = (low_left == 0);
      if (low_left > 0) low_left--;
      step(p, s, ($urandom_range(0, 49) == 0));
      prev_p = p;
      if ($urandom_range(0, 999) == 0) mid_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
